// File: rtl/cpu6502_int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu6502_int_ctrl_pkg
// Brief    : Shared encodings for the cpu6502 interrupt/reset sequencer:
//            sequencer states, interrupt source codes and default vector
//            low bytes.
// Revision : 1.0  initial release
// ============================================================================
package cpu6502_int_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        INT_RST_PEND = 2'd0,
        INT_IDLE     = 2'd1,
        INT_SVC      = 2'd2
    } int_state_t;

    // Source of the BRK sequence currently being serviced
    typedef enum logic [1:0] {
        INT_SRC_RST = 2'd0,
        INT_SRC_NMI = 2'd1,
        INT_SRC_IRQ = 2'd2,
        INT_SRC_BRK = 2'd3
    } int_src_t;

    // Default vector low bytes ($FFFA NMI, $FFFC reset, $FFFE IRQ/BRK)
    localparam logic [7:0] c_nmi_vec_lo = 8'hFA;
    localparam logic [7:0] c_rst_vec_lo = 8'hFC;
    localparam logic [7:0] c_irq_vec_lo = 8'hFE;

endpackage : cpu6502_int_ctrl_pkg
`default_nettype wire

// File: rtl/cpu6502_int_sync.sv
`default_nettype none
// ============================================================================
// Module   : cpu6502_int_sync
// Brief    : Two-flop synchronizer for an asynchronous active-low interrupt
//            pin. Both flops reset to 1 (pin inactive).
// Revision : 1.0  initial release
// ============================================================================
module cpu6502_int_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation into the clk domain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : cpu6502_int_sync
`default_nettype wire

// File: rtl/cpu6502_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu6502_int_ctrl
// Brief    : Interrupt/reset sequencer for cpu6502. Prioritises
//            RESET > NMI > IRQ, injects BRK at opcode fetch, selects the
//            vector low byte, drives the pushed B value and turns the
//            reset-entry pushes into reads.
//            Build option: CPU6502_INT_SYNC_EN routes nmi_n/irq_n through
//            2-flop synchronizers (adds 2 cycles of latency on both).
// Revision : 1.0  initial release
// ============================================================================
module cpu6502_int_ctrl
    import cpu6502_int_ctrl_pkg::*;
#(
    parameter logic [7:0] NMI_VEC_LO = c_nmi_vec_lo,
    parameter logic [7:0] RST_VEC_LO = c_rst_vec_lo,
    parameter logic [7:0] IRQ_VEC_LO = c_irq_vec_lo
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       sync,
    input  logic       i_flag,
    input  logic       brk_op,
    input  logic       vec_ack,
    output logic       force_brk,
    output logic [7:0] vector_lo,
    output logic       b_flag,
    output logic       wr_inhibit,
    output logic       int_busy
);

    int_state_t r_state;
    int_state_t w_state_nxt;
    int_src_t   r_src;
    int_src_t   w_src_nxt;
    logic       r_brk_b;
    logic       w_brk_b_nxt;
    logic       r_nmi_q;
    logic       r_nmi_pend;
    logic       w_nmi_pin;
    logic       w_irq_pin;
    logic       w_nmi_edge;
    logic       w_irq_take;

`ifdef CPU6502_INT_SYNC_EN
    cpu6502_int_sync u_nmi_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (nmi_n),
        .q       (w_nmi_pin)
    );

    cpu6502_int_sync u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (irq_n),
        .q       (w_irq_pin)
    );
`else
    assign w_nmi_pin = nmi_n;
    assign w_irq_pin = irq_n;
`endif

    assign w_nmi_edge = r_nmi_q & ~w_nmi_pin;
    assign w_irq_take = ~w_irq_pin & ~i_flag;
    assign int_busy   = (r_state != INT_IDLE);

    // Delayed NMI pin copy; it keeps tracking during reset so a pin held low
    // across reset is not mistaken for a fresh falling edge afterwards.
    always_ff @(posedge clk) begin
        r_nmi_q <= w_nmi_pin;
    end

    // NMI pending latch: set on a falling edge, cleared when the NMI vector is
    // fetched; a coincident new edge keeps it set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_nmi_pend <= 1'b0;
        end else if (w_nmi_edge) begin
            r_nmi_pend <= 1'b1;
        end else if (r_state == INT_SVC && vec_ack && r_src == INT_SRC_NMI) begin
            r_nmi_pend <= 1'b0;
        end
    end

    // Sequencer state, serviced source and latched B value
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= INT_RST_PEND;
            r_src   <= INT_SRC_RST;
            r_brk_b <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_brk_b <= w_brk_b_nxt;
        end
    end

    // Next-state selection and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_brk_b_nxt = r_brk_b;
        force_brk   = 1'b0;
        vector_lo   = IRQ_VEC_LO;
        b_flag      = 1'b0;
        wr_inhibit  = 1'b0;

        case (r_state)
            INT_RST_PEND: begin
                vector_lo  = RST_VEC_LO;
                wr_inhibit = 1'b1;
                if (sync) begin
                    force_brk   = 1'b1;
                    w_state_nxt = INT_SVC;
                    w_src_nxt   = INT_SRC_RST;
                    w_brk_b_nxt = 1'b0;
                end
            end

            INT_IDLE: begin
                if (sync) begin
                    if (r_nmi_pend) begin
                        force_brk   = 1'b1;
                        w_state_nxt = INT_SVC;
                        w_src_nxt   = INT_SRC_NMI;
                        w_brk_b_nxt = 1'b0;
                    end else if (w_irq_take) begin
                        force_brk   = 1'b1;
                        w_state_nxt = INT_SVC;
                        w_src_nxt   = INT_SRC_IRQ;
                        w_brk_b_nxt = 1'b0;
                    end else if (brk_op) begin
                        // Real opcode 00 runs untouched; only the source is noted
                        w_state_nxt = INT_SVC;
                        w_src_nxt   = INT_SRC_BRK;
                        w_brk_b_nxt = 1'b1;
                    end
                end
            end

            INT_SVC: begin
                case (r_src)
                    INT_SRC_RST: begin
                        vector_lo  = RST_VEC_LO;
                        wr_inhibit = 1'b1;
                    end
                    INT_SRC_NMI: vector_lo = NMI_VEC_LO;
                    default:     vector_lo = IRQ_VEC_LO;
                endcase
                // B keeps the value chosen at entry, even after an NMI hijack
                b_flag = r_brk_b;
                if (vec_ack) begin
                    w_state_nxt = INT_IDLE;
                end else if (r_nmi_pend &&
                             (r_src == INT_SRC_IRQ || r_src == INT_SRC_BRK)) begin
                    w_src_nxt = INT_SRC_NMI;
                end
            end

            default: begin
                w_state_nxt = INT_RST_PEND;
                w_src_nxt   = INT_SRC_RST;
                w_brk_b_nxt = 1'b0;
            end
        endcase
    end

    // The core must never fetch an opcode while a BRK sequence is in flight
    a_no_sync_in_svc: assert property (
        @(posedge clk) disable iff (!reset_n) !(r_state == INT_SVC && sync)
    );

endmodule : cpu6502_int_ctrl
`default_nettype wire

// File: tb/tb_cpu6502_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu6502_int_ctrl
// Brief    : Scoreboard bench for cpu6502_int_ctrl. Stimulus pushes the
//            expected output set for each cycle; a monitor on the falling
//            edge pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu6502_int_ctrl;

`ifdef CPU6502_INT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic       nmi_n;
    logic       irq_n;
    logic       sync;
    logic       i_flag;
    logic       brk_op;
    logic       vec_ack;
    logic       force_brk;
    logic [7:0] vector_lo;
    logic       b_flag;
    logic       wr_inhibit;
    logic       int_busy;

    typedef struct {
        string       name;
        logic [11:0] val;   // {force_brk, vector_lo, b_flag, wr_inhibit, int_busy}
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_e;
    logic [11:0] m_act;
    int          checks = 0;
    int          errors = 0;

    cpu6502_int_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .nmi_n      (nmi_n),
        .irq_n      (irq_n),
        .sync       (sync),
        .i_flag     (i_flag),
        .brk_op     (brk_op),
        .vec_ack    (vec_ack),
        .force_brk  (force_brk),
        .vector_lo  (vector_lo),
        .b_flag     (b_flag),
        .wr_inhibit (wr_inhibit),
        .int_busy   (int_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            m_e   = sb_q.pop_front();
            m_act = {force_brk, vector_lo, b_flag, wr_inhibit, int_busy};
            checks++;
            if (m_act !== m_e.val) begin
                errors++;
                $display("FAIL %s: got fb=%b vec=%h b=%b wi=%b busy=%b, expected fb=%b vec=%h b=%b wi=%b busy=%b",
                         m_e.name, m_act[11], m_act[10:3], m_act[2], m_act[1], m_act[0],
                         m_e.val[11], m_e.val[10:3], m_e.val[2], m_e.val[1], m_e.val[0]);
            end
        end
    end

    // Queue the expectation for the current cycle, then advance one clock
    task automatic step(input string nm, input logic fb, input logic [7:0] vl,
                        input logic bf, input logic wi, input logic busy);
        exp_t e;
        e.name = nm;
        e.val  = {fb, vl, bf, wi, busy};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input string nm, input logic fb, input logic [7:0] vl,
                        input logic bf, input logic wi, input logic busy);
        for (int k = 0; k < n; k++) step(nm, fb, vl, bf, wi, busy);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; sync = 1'b0;
        i_flag  = 1'b1; brk_op = 1'b0; vec_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset entry
        reset_n = 1'b1;
        step("reset_state",   1'b0, 8'hFC, 1'b0, 1'b1, 1'b1);
        sync = 1'b1;
        step("rst_inject",    1'b1, 8'hFC, 1'b0, 1'b1, 1'b1);
        sync = 1'b0;
        step("rst_svc",       1'b0, 8'hFC, 1'b0, 1'b1, 1'b1);
        vec_ack = 1'b1;
        step("rst_ack",       1'b0, 8'hFC, 1'b0, 1'b1, 1'b1);
        vec_ack = 1'b0;
        step("rst_done",      1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // IRQ masked, then unmasked
        irq_n = 1'b0;
        hold(1 + LAT, "irq_settle", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b1;
        step("irq_masked",    1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        i_flag = 1'b0;
        step("irq_inject",    1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0; i_flag = 1'b1;
        step("irq_svc",       1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
        irq_n = 1'b1; vec_ack = 1'b1;
        step("irq_ack",       1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
        vec_ack = 1'b0;
        hold(1 + LAT, "irq_done", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // NMI falling edge, held low afterwards
        nmi_n = 1'b0;
        hold(1 + LAT, "nmi_edge", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b1;
        step("nmi_inject",    1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0;
        step("nmi_svc",       1'b0, 8'hFA, 1'b0, 1'b0, 1'b1);
        vec_ack = 1'b1;
        step("nmi_ack",       1'b0, 8'hFA, 1'b0, 1'b0, 1'b1);
        vec_ack = 1'b0; sync = 1'b1;
        step("nmi_no_retrig0", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        step("nmi_no_retrig1", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0; nmi_n = 1'b1;
        hold(1 + LAT, "nmi_release", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // Priority: pending NMI beats live IRQ and a fetched BRK
        nmi_n = 1'b0;
        hold(1 + LAT, "prio_edge", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b1; irq_n = 1'b0; i_flag = 1'b0; brk_op = 1'b1;
        step("prio_inject",   1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0; irq_n = 1'b1; i_flag = 1'b1; brk_op = 1'b0;
        step("prio_svc",      1'b0, 8'hFA, 1'b0, 1'b0, 1'b1);
        vec_ack = 1'b1;
        step("prio_ack",      1'b0, 8'hFA, 1'b0, 1'b0, 1'b1);
        vec_ack = 1'b0; nmi_n = 1'b1;
        hold(1 + LAT, "prio_done", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // Software BRK hijacked by an NMI edge before the vector fetch
        sync = 1'b1; brk_op = 1'b1;
        step("brk_fetch",     1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0; brk_op = 1'b0; nmi_n = 1'b0;
        hold(2 + LAT, "brk_svc", 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
        step("hijack",        1'b0, 8'hFA, 1'b1, 1'b0, 1'b1);
        vec_ack = 1'b1;
        step("hijack_ack",    1'b0, 8'hFA, 1'b1, 1'b0, 1'b1);
        vec_ack = 1'b0; nmi_n = 1'b1; sync = 1'b1;
        step("hijack_no_repeat", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0;
        hold(1 + LAT, "idle_gap", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an IRQ sequence with an NMI pending
        irq_n = 1'b0; i_flag = 1'b0;
        hold(1 + LAT, "mid_irq_settle", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b1;
        step("mid_irq_inject", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0; i_flag = 1'b1; irq_n = 1'b1; nmi_n = 1'b0;
        step("mid_irq_svc",   1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        step("mid_pre_rst",   1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1; nmi_n = 1'b1;
        step("mid_rst",       1'b0, 8'hFC, 1'b0, 1'b1, 1'b1);
        sync = 1'b1;
        step("mid_rst_inject", 1'b1, 8'hFC, 1'b0, 1'b1, 1'b1);
        sync = 1'b0; vec_ack = 1'b1;
        step("mid_rst_ack",   1'b0, 8'hFC, 1'b0, 1'b1, 1'b1);
        vec_ack = 1'b0; sync = 1'b1;
        step("mid_pend_cleared", 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        sync = 1'b0;
        step("end_idle",      1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cpu6502_int_ctrl
`default_nettype wire
